// File: rtl/wb_select_stage.sv
// MEM/WB writeback-select stage: picks result and destination, registers it,
// and bypasses the registered write to the operand read ports.
module wb_select_stage #(
    parameter int DATA_W   = 32,
    parameter int ADDR_W   = 5,
    parameter int NSRC     = 4,
    parameter int NRD      = 2,
    parameter int LINK_REG = 31,
    parameter int CNT_W    = 16,
    localparam int SEL_W   = $clog2(NSRC)
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   in_valid,
    input  logic [NSRC*DATA_W-1:0] in_src_data,
    input  logic [SEL_W-1:0]       in_src_sel,
    input  logic [ADDR_W-1:0]      in_rt,
    input  logic [ADDR_W-1:0]      in_rd,
    input  logic [1:0]             in_dst_mode,
    input  logic                   stall,
    input  logic                   flush,
    input  logic [NRD*ADDR_W-1:0]  rd_addr,
    input  logic [NRD*DATA_W-1:0]  rf_data,
    output logic [NRD*DATA_W-1:0]  fwd_data,
    output logic [NRD-1:0]         fwd_hit,
    output logic                   wb_valid,
    output logic                   wb_we,
    output logic [ADDR_W-1:0]      wb_addr,
    output logic [DATA_W-1:0]      wb_data,
    output logic                   sel_err,
    output logic [CNT_W-1:0]       wb_count
);

    logic [DATA_W-1:0] data_n;
    logic [ADDR_W-1:0] addr_n;
    logic              we_n;
    logic              sel_bad;

    logic              valid_q, valid_d;
    logic              we_q, we_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] data_q, data_d;
    logic              err_q, err_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;

    // Selects that match no source leave the result at zero.
    always_comb begin
        data_n = '0;
        for (int k = 0; k < NSRC; k++) begin
            if (in_src_sel == SEL_W'(k)) begin
                data_n = in_src_data[k*DATA_W +: DATA_W];
            end
        end
    end

    assign sel_bad = ({1'b0, in_src_sel} >= (SEL_W+1)'(NSRC));

    always_comb begin
        unique case (in_dst_mode)
            2'b00:   addr_n = in_rt;
            2'b01:   addr_n = in_rd;
            2'b10:   addr_n = ADDR_W'(LINK_REG);
            default: addr_n = '0;
        endcase
    end

    assign we_n = in_valid && (in_dst_mode != 2'b11) && (addr_n != '0);

    always_comb begin
        valid_d = valid_q;
        we_d    = we_q;
        addr_d  = addr_q;
        data_d  = data_q;
        err_d   = err_q;
        cnt_d   = cnt_q;
        if (flush) begin
            valid_d = 1'b0;
            we_d    = 1'b0;
            addr_d  = '0;
            data_d  = '0;
        end else if (!stall) begin
            valid_d = in_valid;
            we_d    = we_n;
            addr_d  = addr_n;
            data_d  = data_n;
            err_d   = err_q || (in_valid && sel_bad);
            cnt_d   = we_n ? cnt_q + CNT_W'(1) : cnt_q;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            valid_q <= 1'b0;
            we_q    <= 1'b0;
            addr_q  <= '0;
            data_q  <= '0;
            err_q   <= 1'b0;
            cnt_q   <= '0;
        end else begin
            valid_q <= valid_d;
            we_q    <= we_d;
            addr_q  <= addr_d;
            data_q  <= data_d;
            err_q   <= err_d;
            cnt_q   <= cnt_d;
        end
    end

    assign wb_valid = valid_q;
    assign wb_we    = we_q;
    assign wb_addr  = addr_q;
    assign wb_data  = data_q;
    assign sel_err  = err_q;
    assign wb_count = cnt_q;

    // Each read port compares independently; $0 never takes bypassed data.
    for (genvar i = 0; i < NRD; i++) begin : g_byp
        logic [ADDR_W-1:0] ra;
        assign ra = rd_addr[i*ADDR_W +: ADDR_W];
        assign fwd_hit[i] = we_q && (addr_q == ra) && (ra != '0);
        assign fwd_data[i*DATA_W +: DATA_W] =
            fwd_hit[i] ? data_q : rf_data[i*DATA_W +: DATA_W];
    end

endmodule
